// File: rtl/sl_pkg.sv
// sl_pkg: definitions shared by the SL transmitter and receiver.
//   sl_state_t    : frame sequencing states
//   SL_LEN_MIN/MAX: legal word-length range (length must also be even)
//   SL_IDLE_LEVEL : resting level of both active-low lines
//   sl_parity()   : parity bit that makes the frame's count of ones odd
package sl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        BIT_LOW,
        BIT_HIGH,
        PAR_LOW,
        PAR_HIGH,
        STOP_LOW,
        STOP_HIGH
    } sl_state_t;

    localparam int   SL_LEN_MIN    = 8;
    localparam int   SL_LEN_MAX    = 32;
    localparam logic SL_IDLE_LEVEL = 1'b1;

    // Bits above the word length must already be masked off by the caller.
    // Returns 1 when the data holds an even number of ones, so data plus
    // parity always carries an odd number of ones.
    function automatic logic sl_parity(input logic [31:0] data);
        return ~(^data);
    endfunction

endpackage

// File: rtl/sl_phase_timer.sv
// sl_phase_timer: loadable down-counter timing one LOW or HIGH phase.
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load load_val this cycle (phase entry)
//   load_val   : phase length minus one
//   tc         : terminal count, high while the counter sits at zero
// A phase loaded with L-1 therefore lasts exactly L cycles.
module sl_phase_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             tc
);

    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_val;
        end else if (count_reg != '0) begin
            count_next = count_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign tc = (count_reg == '0);

endmodule

// File: rtl/sl_transmitter.sv
// sl_transmitter: dual-wire serial-line transmitter.
//   clk, rst_n : clock, asynchronous active-low reset
//   tx_start   : send request, sampled only while tx_ready=1
//   tx_data    : word to send, bit 0 first; bits >= tx_len ignored
//   tx_len     : word length, legal when even and LEN_MIN..LEN_MAX
//   tx_ready   : idle, a request will be accepted
//   tx_busy    : a frame is in progress
//   tx_done    : one-cycle pulse when a frame completes
//   tx_err     : one-cycle pulse when a request has an illegal length
//   sl0, sl1   : active-low zeroes / ones lines
// Frame: GUARD, N data bits, parity, stop. Each element is a LOW phase
// on one line (both lines for stop) followed by a both-high HIGH phase.
module sl_transmitter
    import sl_pkg::*;
#(
    parameter int LOW_CYCLES  = 16,
    parameter int HIGH_CYCLES = 16,
    parameter int LEN_MIN     = SL_LEN_MIN,
    parameter int LEN_MAX     = SL_LEN_MAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_start,
    input  logic [31:0] tx_data,
    input  logic [5:0]  tx_len,
    output logic        tx_ready,
    output logic        tx_busy,
    output logic        tx_done,
    output logic        tx_err,
    output logic        sl0,
    output logic        sl1
);

    localparam int MAX_CYCLES = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
    localparam int TW         = $clog2(MAX_CYCLES);
    localparam logic [TW-1:0] LOW_LOAD  = TW'(LOW_CYCLES - 1);
    localparam logic [TW-1:0] HIGH_LOAD = TW'(HIGH_CYCLES - 1);

    sl_state_t   state_reg, state_next;
    logic [31:0] shreg_reg, shreg_next;
    logic [5:0]  idx_reg, idx_next, idx_inc;
    logic [5:0]  len_reg, len_next;
    logic        par_reg, par_next;
    logic        sl0_reg, sl0_next;
    logic        sl1_reg, sl1_next;
    logic        ready_reg, ready_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;

    logic          tmr_load;
    logic [TW-1:0] tmr_load_val;
    logic          tmr_tc;

    // Mask of the bits that belong to the requested word.
    logic [31:0] len_mask;
    for (genvar gi = 0; gi < 32; gi++) begin : g_len_mask
        assign len_mask[gi] = (tx_len > 6'(gi));
    end

    logic len_legal;
    assign len_legal = !tx_len[0] && (tx_len >= 6'(LEN_MIN)) && (tx_len <= 6'(LEN_MAX));

    sl_phase_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (tmr_load),
        .load_val(tmr_load_val),
        .tc      (tmr_tc)
    );

    always_comb begin
        state_next   = state_reg;
        shreg_next   = shreg_reg;
        idx_next     = idx_reg;
        len_next     = len_reg;
        par_next     = par_reg;
        tmr_load     = 1'b0;
        tmr_load_val = HIGH_LOAD;
        done_next    = 1'b0;
        err_next     = 1'b0;
        idx_inc      = (idx_reg < len_reg) ? idx_reg + 6'd1 : idx_reg;

        case (state_reg)
            IDLE: begin
                if (tx_start) begin
                    if (len_legal) begin
                        shreg_next   = tx_data & len_mask;
                        len_next     = tx_len;
                        par_next     = sl_parity(tx_data & len_mask);
                        idx_next     = '0;
                        state_next   = GUARD;
                        tmr_load     = 1'b1;
                        tmr_load_val = HIGH_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            GUARD: begin
                if (tmr_tc) begin
                    state_next   = BIT_LOW;
                    tmr_load     = 1'b1;
                    tmr_load_val = LOW_LOAD;
                end
            end
            BIT_LOW: begin
                if (tmr_tc) begin
                    state_next   = BIT_HIGH;
                    tmr_load     = 1'b1;
                    tmr_load_val = HIGH_LOAD;
                end
            end
            BIT_HIGH: begin
                if (tmr_tc) begin
                    shreg_next   = shreg_reg >> 1;
                    idx_next     = idx_inc;
                    state_next   = (idx_inc < len_reg) ? BIT_LOW : PAR_LOW;
                    tmr_load     = 1'b1;
                    tmr_load_val = LOW_LOAD;
                end
            end
            PAR_LOW: begin
                if (tmr_tc) begin
                    state_next   = PAR_HIGH;
                    tmr_load     = 1'b1;
                    tmr_load_val = HIGH_LOAD;
                end
            end
            PAR_HIGH: begin
                if (tmr_tc) begin
                    state_next   = STOP_LOW;
                    tmr_load     = 1'b1;
                    tmr_load_val = LOW_LOAD;
                end
            end
            STOP_LOW: begin
                if (tmr_tc) begin
                    state_next   = STOP_HIGH;
                    tmr_load     = 1'b1;
                    tmr_load_val = HIGH_LOAD;
                end
            end
            STOP_HIGH: begin
                if (tmr_tc) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Lines are registered from the state being entered, so a pulse
        // starts on the same edge as its LOW phase. Only STOP_LOW pulls
        // both lines low.
        sl0_next = SL_IDLE_LEVEL;
        sl1_next = SL_IDLE_LEVEL;
        case (state_next)
            BIT_LOW: begin
                sl0_next = shreg_next[0];
                sl1_next = ~shreg_next[0];
            end
            PAR_LOW: begin
                sl0_next = par_next;
                sl1_next = ~par_next;
            end
            STOP_LOW: begin
                sl0_next = ~SL_IDLE_LEVEL;
                sl1_next = ~SL_IDLE_LEVEL;
            end
            default: ;
        endcase

        ready_next = (state_next == IDLE);
        busy_next  = (state_next != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            idx_reg   <= '0;
            len_reg   <= '0;
            par_reg   <= 1'b0;
            sl0_reg   <= SL_IDLE_LEVEL;
            sl1_reg   <= SL_IDLE_LEVEL;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            idx_reg   <= idx_next;
            len_reg   <= len_next;
            par_reg   <= par_next;
            sl0_reg   <= sl0_next;
            sl1_reg   <= sl1_next;
            ready_reg <= ready_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    assign tx_ready = ready_reg;
    assign tx_busy  = busy_reg;
    assign tx_done  = done_reg;
    assign tx_err   = err_reg;
    assign sl0      = sl0_reg;
    assign sl1      = sl1_reg;

endmodule

// File: tb/tb_sl_transmitter.sv
// tb_sl_transmitter: randomized and directed bench for sl_transmitter.
// A frame-level model (offset since accept -> expected line levels) is
// compared against every DUT output on each falling edge, and a small
// line decoder recovers the sent bits for per-frame checks.
module tb_sl_transmitter;

    localparam int L = 16;
    localparam int H = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tx_start = 1'b0;
    logic [31:0] tx_data = '0;
    logic [5:0]  tx_len = '0;
    logic        tx_ready, tx_busy, tx_done, tx_err, sl0, sl1;

    sl_transmitter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .tx_start(tx_start),
        .tx_data (tx_data),
        .tx_len  (tx_len),
        .tx_ready(tx_ready),
        .tx_busy (tx_busy),
        .tx_done (tx_done),
        .tx_err  (tx_err),
        .sl0     (sl0),
        .sl1     (sl1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int frame_len(input int n);
        return H + (n + 2) * (L + H);
    endfunction

    function automatic bit legal(input int n);
        return (n % 2 == 0) && (n >= 8) && (n <= 32);
    endfunction

    function automatic bit parity_of(input logic [31:0] d, input int n);
        logic [63:0] m;
        m = (64'd1 << n) - 64'd1;
        return ($countones(d & m[31:0]) % 2) == 0;
    endfunction

    // Expected line levels at offset k after the accepting edge.
    function automatic void exp_lines(input int k, input logic [31:0] d, input int n,
                                      input bit p, output bit e0, output bit e1);
        int j, r;
        bit b;
        e0 = 1'b1;
        e1 = 1'b1;
        if (k >= H) begin
            j = (k - H) / (L + H);
            r = (k - H) % (L + H);
            if (r < L) begin
                if (j == n + 1) begin
                    e0 = 1'b0;
                    e1 = 1'b0;
                end else begin
                    b = (j < n) ? d[j] : p;
                    if (b) e1 = 1'b0;
                    else   e0 = 1'b0;
                end
            end
        end
    endfunction

    // Frame-level reference model.
    bit          m_active, m_done, m_err, m_par;
    int          m_k, m_len;
    logic [31:0] m_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_err    <= 1'b0;
            m_k      <= 0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            if (m_active) begin
                if (m_k + 1 == frame_len(m_len)) begin
                    m_active <= 1'b0;
                    m_done   <= 1'b1;
                end else begin
                    m_k <= m_k + 1;
                end
            end else if (tx_start) begin
                if (legal(int'(tx_len))) begin
                    m_active <= 1'b1;
                    m_k      <= 0;
                    m_data   <= tx_data;
                    m_len    <= int'(tx_len);
                    m_par    <= parity_of(tx_data, int'(tx_len));
                end else begin
                    m_err <= 1'b1;
                end
            end
        end
    end

    // Per-cycle compare plus line decoder.
    bit e0_c, e1_c;
    bit rx_bits[$];
    int stop_cnt = 0;
    bit prev0 = 1'b1, prev1 = 1'b1;

    always @(negedge clk) begin
        if (rst_n) begin
            e0_c = 1'b1;
            e1_c = 1'b1;
            if (m_active) exp_lines(m_k, m_data, m_len, m_par, e0_c, e1_c);
            chk("sl0", sl0, e0_c);
            chk("sl1", sl1, e1_c);
            chk("tx_ready", tx_ready, !m_active);
            chk("tx_busy", tx_busy, m_active);
            chk("tx_done", tx_done, m_done);
            chk("tx_err", tx_err, m_err);
            if (prev0 && prev1) begin
                if (!sl0 && !sl1) stop_cnt++;
                else if (!sl0) rx_bits.push_back(1'b0);
                else if (!sl1) rx_bits.push_back(1'b1);
            end
            prev0 = sl0;
            prev1 = sl1;
        end
    end

    function automatic logic [63:0] rx_value();
        logic [63:0] v;
        v = '0;
        foreach (rx_bits[i]) if (i < 64) v[i] = rx_bits[i];
        return v;
    endfunction

    task automatic wait_ready();
        int g;
        g = 0;
        while (!tx_ready && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) chk("ready_wait", tx_ready, 1);
    endtask

    // Called and returns on a falling edge. Optionally pulses tx_start
    // inject_at cycles into the frame.
    task automatic send(input logic [31:0] d, input int n, input int inject_at, output int lat);
        wait_ready();
        rx_bits.delete();
        stop_cnt = 0;
        tx_data  = d;
        tx_len   = 6'(n);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        lat = 0;
        while (lat < 3000) begin
            @(negedge clk);
            lat++;
            if (lat == inject_at) begin
                tx_start = 1'b1;
                tx_data  = $urandom;
                tx_len   = 6'd8;
            end else begin
                tx_start = 1'b0;
            end
            if (tx_done) break;
        end
        tx_start = 1'b0;
        if (lat >= 3000) chk("done_wait", tx_done, 1);
        $display("frame len=%0d data=%08h inject=%0d latency=%0d decoded=%0h",
                 n, d, inject_at, lat, rx_value());
    endtask

    task automatic check_frame(input logic [31:0] d, input int n, input int lat);
        logic [63:0] mask;
        int p;
        mask = (64'd1 << n) - 64'd1;
        p = (rx_bits.size() > n) ? int'(rx_bits[n]) : 2;
        chk("latency", lat, frame_len(n));
        chk("rx_count", rx_bits.size(), n + 1);
        chk("rx_word", rx_value() & mask, {32'd0, d} & mask);
        chk("rx_parity", p, parity_of(d, n));
        chk("rx_ones_odd", $countones(rx_value() & ((mask << 1) | 64'd1)) % 2, 1);
        chk("stop_count", stop_cnt, 1);
    endtask

    task automatic reject(input int n);
        int e, b, lo;
        e = 0; b = 0; lo = 0;
        wait_ready();
        tx_len   = 6'(n);
        tx_data  = $urandom;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (tx_err) e++;
            if (tx_busy) b++;
            if (!sl0 || !sl1) lo++;
            @(negedge clk);
        end
        chk("err_pulses", e, 1);
        chk("err_busy", b, 0);
        chk("err_lines", lo, 0);
        $display("reject len=%0d err_cycles=%0d", n, e);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, n, inj, cnt;
        logic [31:0] d;

        repeat (3) @(negedge clk);
        chk("rst_sl0", sl0, 1);
        chk("rst_sl1", sl1, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        send(32'hA5, 8, 0, lat);
        check_frame(32'hA5, 8, lat);
        chk("a5_latency", lat, 336);
        chk("a5_bits", rx_value(), 64'h1A5);

        send(32'h0001, 16, 0, lat);
        check_frame(32'h0001, 16, lat);
        chk("w16_latency", lat, 592);
        chk("w16_bits", rx_value(), 64'h00001);

        send(32'hFFFF_FFFF, 32, 0, lat);
        check_frame(32'hFFFF_FFFF, 32, lat);
        chk("w32_latency", lat, 1104);
        chk("w32_bits", rx_value(), 64'h1_FFFF_FFFF);

        reject(7);
        reject(34);

        // Start while busy is ignored; then back-to-back at earliest edge.
        send(32'hA5, 8, 100, lat);
        check_frame(32'hA5, 8, lat);
        chk("inject_latency", lat, 336);
        send(32'h3C, 8, 0, lat);
        check_frame(32'h3C, 8, lat);

        // Reset during the LOW phase of bit 3 (a zero, so sl0 is low).
        tx_data  = 32'hA5;
        tx_len   = 6'd8;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (114) @(negedge clk);
        chk("bit3_sl0", sl0, 0);
        chk("bit3_sl1", sl1, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_sl0", sl0, 1);
        chk("async_sl1", sl1, 1);
        chk("async_ready", tx_ready, 1);
        chk("async_busy", tx_busy, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tx_done) cnt++;
        end
        chk("no_done_after_rst", cnt, 0);
        $display("reset mid-frame, done pulses afterwards=%0d", cnt);
        send(32'hA5, 8, 0, lat);
        check_frame(32'hA5, 8, lat);

        for (int it = 0; it < 12; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                do n = $urandom_range(0, 63); while (legal(n));
                reject(n);
            end else begin
                n   = 2 * $urandom_range(4, 16);
                d   = $urandom;
                inj = ($urandom_range(0, 1) == 1) ? $urandom_range(1, frame_len(n) - 2) : 0;
                send(d, n, inj, lat);
                check_frame(d, n, lat);
            end
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
